// File: rtl/spm_arbiter_pkg.sv
// spm_arbiter_pkg: shared strobe/direction encodings, owner states and starvation defaults for the SPM port-B arbiter
package spm_arbiter_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int STARVE_LIMIT_DEF = 7;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_MEM  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Saturating count of consecutive cycles DMA waited; any cycle it is not waiting clears it.
    function automatic logic [3:0] starve_next(input logic [3:0] cnt, input logic waiting, input logic [3:0] limit);
        return !waiting ? 4'd0 : (cnt == limit ? limit : cnt + 4'd1);
    endfunction

endpackage

// File: rtl/spm_arbiter.sv
// spm_arbiter: fixed MEM-priority arbiter with DMA anti-starvation in front of SPM port B, one access per cycle
module spm_arbiter
    import spm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [11:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    output logic        mem_gnt,
    output logic        mem_ack,
    output logic [31:0] mem_rd_data,
    input  logic        dma_req,
    input  logic        dma_rw,
    input  logic [11:0] dma_addr,
    input  logic [31:0] dma_wr_data,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [31:0] dma_rd_data,
    output logic [11:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t     owner;
    logic [3:0] starve_cnt;
    logic       starved;

    always_comb begin
        starved     = starve_cnt == LIMIT;
        mem_gnt     = reset_ && mem_req && !(dma_req && starved);
        dma_gnt     = reset_ && dma_req && (!mem_req || starved);
        spm_as_     = (mem_gnt || dma_gnt) ? ENABLE_ : DISABLE_;
        spm_rw      = mem_gnt ? mem_rw : dma_gnt ? dma_rw : READ;
        spm_addr    = mem_gnt ? mem_addr : dma_gnt ? dma_addr : 12'd0;
        spm_wr_data = mem_gnt ? mem_wr_data : dma_gnt ? dma_wr_data : 32'd0;
        // Gating with reset_ kills the ack of an access issued just before reset asserts.
        mem_ack     = reset_ && owner == OWN_MEM;
        dma_ack     = reset_ && owner == OWN_DMA;
        mem_rd_data = spm_rd_data;
        dma_rd_data = spm_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            owner      <= OWN_IDLE;
            starve_cnt <= 4'd0;
        end else begin
            owner      <= mem_gnt ? OWN_MEM : dma_gnt ? OWN_DMA : OWN_IDLE;
            starve_cnt <= starve_next(starve_cnt, dma_req && !dma_gnt, LIMIT);
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
// tb_spm_arbiter: randomized and directed scoreboard bench for spm_arbiter against a behavioural arbitration and memory model
module tb_spm_arbiter;
    import spm_arbiter_pkg::*;

    localparam int LIMIT = 7;

    typedef struct {
        logic        req;
        logic        rw;
        logic [11:0] addr;
        logic [31:0] data;
    } rq_t;

    typedef struct {
        logic        dma;
        logic        rd;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        mem_req = 1'b0, mem_rw = 1'b1, dma_req = 1'b0, dma_rw = 1'b1;
    logic [11:0] mem_addr = '0, dma_addr = '0;
    logic [31:0] mem_wr_data = '0, dma_wr_data = '0;
    logic        mem_gnt, mem_ack, dma_gnt, dma_ack, spm_as_, spm_rw;
    logic [31:0] mem_rd_data, dma_rd_data, spm_wr_data;
    logic [31:0] spm_rd_data = '0;
    logic [11:0] spm_addr;

    logic [31:0] spm_mem [4096];
    logic [31:0] shadow  [4096];
    sb_t         sb [$];
    sb_t         head;
    int          cyc = 0, denied = 0, total = 0, bad = 0;
    logic        done = 1'b0;

    spm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_(reset_),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_gnt(mem_gnt), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rd_data(dma_rd_data),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPM port B: writes land at the edge, reads return one cycle later
    always @(posedge clk)
        if (spm_as_ == ENABLE_) begin
            if (spm_rw == WRITE) spm_mem[spm_addr] <= spm_wr_data;
            else spm_rd_data <= spm_mem[spm_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic rq_t mk(input logic req, input logic rw, input logic [11:0] addr, input logic [31:0] data);
        rq_t r;
        r.req = req; r.rw = rw; r.addr = addr; r.data = data;
        return r;
    endfunction

    // One clock cycle: drive, predict the grant from the arbitration rules, check the SPM side, queue the ack
    task automatic step(input logic rs, input rq_t m, input rq_t d, output logic mg, output logic dg);
        sb_t e;
        @(negedge clk);
        reset_ = rs;
        mem_req = m.req; mem_rw = m.rw; mem_addr = m.addr; mem_wr_data = m.data;
        dma_req = d.req; dma_rw = d.rw; dma_addr = d.addr; dma_wr_data = d.data;
        #1;
        dg = rs && d.req && (!m.req || denied == LIMIT);
        mg = rs && m.req && !dg;
        chk("mem_gnt", 32'(mem_gnt), 32'(mg));
        chk("dma_gnt", 32'(dma_gnt), 32'(dg));
        chk("spm_as_", 32'(spm_as_), 32'((mg || dg) ? ENABLE_ : DISABLE_));
        chk("spm_addr", 32'(spm_addr), 32'(mg ? m.addr : dg ? d.addr : 12'd0));
        chk("spm_rw", 32'(spm_rw), 32'(mg ? m.rw : dg ? d.rw : READ));
        chk("spm_wr_data", spm_wr_data, mg ? m.data : dg ? d.data : 32'd0);
        if (mg || dg) begin
            e.dma = dg;
            e.rd = mg ? m.rw == READ : d.rw == READ;
            e.data = shadow[mg ? m.addr : d.addr];
            e.cyc = cyc;
            sb.push_back(e);
            if (!e.rd) shadow[mg ? m.addr : d.addr] = mg ? m.data : d.data;
        end
        denied = (rs && d.req && !dg) ? (denied < LIMIT ? denied + 1 : LIMIT) : 0;
    endtask

    // Monitor: each cycle the ack (if any) must match the access issued one cycle earlier
    always @(negedge clk) begin
        #2;
        if (!done) begin
            logic em, ed;
            em = 1'b0; ed = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                head = sb.pop_front();
                em = reset_ && !head.dma;
                ed = reset_ && head.dma;
            end
            chk("mem_ack", 32'(mem_ack), 32'(em));
            chk("dma_ack", 32'(dma_ack), 32'(ed));
            if (em && head.rd) chk("mem_rd_data", mem_rd_data, head.data);
            if (ed && head.rd) chk("dma_rd_data", dma_rd_data, head.data);
        end
    end

    initial begin
        rq_t idle, mp, dp;
        logic mg, dg;
        int first, n;
        for (int i = 0; i < 4096; i++) begin
            spm_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            shadow[i]  = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end
        spm_mem[12'h010] = 32'hDEAD_BEEF;
        shadow[12'h010]  = 32'hDEAD_BEEF;
        idle = mk(1'b0, READ, 12'd0, 32'd0);
        step(1'b0, idle, idle, mg, dg);
        step(1'b0, mk(1'b1, WRITE, 12'h005, 32'h1), mk(1'b1, WRITE, 12'h006, 32'h2), mg, dg);
        step(1'b1, idle, idle, mg, dg);
        // MEM read of the preloaded word
        step(1'b1, mk(1'b1, READ, 12'h010, 32'd0), idle, mg, dg);
        step(1'b1, idle, idle, mg, dg);
        // DMA write then MEM read of the same word next cycle
        step(1'b1, idle, mk(1'b1, WRITE, 12'h020, 32'h1234_5678), mg, dg);
        step(1'b1, mk(1'b1, READ, 12'h020, 32'd0), idle, mg, dg);
        // Back-to-back MEM reads
        for (int i = 0; i < 4; i++) step(1'b1, mk(1'b1, READ, 12'(i), 32'd0), idle, mg, dg);
        step(1'b1, idle, idle, mg, dg);
        // Continuous contention: DMA wins every eighth cycle
        first = 0; n = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, mk(1'b1, READ, 12'(i), 32'd0), mk(1'b1, READ, 12'(i + 100), 32'd0), mg, dg);
            if (dg) begin
                n++;
                if (first == 0) first = i;
            end
        end
        chk("starve_first", 32'(first), 32'(LIMIT + 1));
        chk("starve_count", 32'(n), 32'd2);
        step(1'b1, idle, idle, mg, dg);
        // Reset in the cycle after a DMA grant
        step(1'b1, idle, mk(1'b1, WRITE, 12'h040, 32'hCAFE_0001), mg, dg);
        step(1'b0, idle, idle, mg, dg);
        step(1'b0, mk(1'b1, READ, 12'h1, 32'd0), mk(1'b1, READ, 12'h2, 32'd0), mg, dg);
        step(1'b1, idle, idle, mg, dg);
        // DMA withdraws a write while MEM holds the port, then contention restarts from zero
        for (int i = 0; i < 3; i++) step(1'b1, mk(1'b1, READ, 12'(i), 32'd0), mk(1'b1, WRITE, 12'h030, 32'hBAD0_BAD0), mg, dg);
        step(1'b1, mk(1'b1, READ, 12'h030, 32'd0), idle, mg, dg);
        first = 0;
        for (int i = 1; i <= LIMIT + 1; i++) begin
            step(1'b1, mk(1'b1, READ, 12'h030, 32'd0), mk(1'b1, READ, 12'h031, 32'd0), mg, dg);
            if (dg && first == 0) first = i;
        end
        chk("cancel_restart", 32'(first), 32'(LIMIT + 1));
        // Randomized traffic obeying hold-until-grant, with occasional cancels and resets
        mp = idle; dp = idle;
        for (int i = 0; i < 600; i++) begin
            if (!mp.req) begin
                if ($urandom_range(0, 99) < 60)
                    mp = mk(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
            end else if ($urandom_range(0, 99) < 4) mp.req = 1'b0;
            if (!dp.req) begin
                if ($urandom_range(0, 99) < 50)
                    dp = mk(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
            end else if ($urandom_range(0, 99) < 4) dp.req = 1'b0;
            step($urandom_range(0, 99) >= 3, mp, dp, mg, dg);
            if (mg) mp.req = 1'b0;
            if (dg) dp.req = 1'b0;
        end
        step(1'b1, idle, idle, mg, dg);
        step(1'b1, idle, idle, mg, dg);
        @(negedge clk);
        #3;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
